// File: rtl/seq_decoder_pkg.sv
// Shared definitions for seq_decoder: mode encodings, FSM state enum and
// the pulse-counter width helper.
// Imported by seq_decoder and onehot_decoder.
package seq_decoder_pkg;

    // Operating mode, sampled together with an accepted load.
    // 2'b11 is reserved and decodes as LEVEL.
    localparam logic [1:0] MODE_LEVEL = 2'b00;
    localparam logic [1:0] MODE_PULSE = 2'b01;
    localparam logic [1:0] MODE_SCAN  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_PULSE = 2'd2,
        ST_SCAN  = 2'd3
    } state_t;

    // The pulse counter counts down from len-1 to 0, so it only has to
    // hold len-1. At least one bit is kept so the vector is never empty.
    function automatic int pulse_cnt_w(input int len);
        return (len <= 2) ? 1 : $clog2(len);
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Combinational index-to-one-hot decoder.
// Ports: idx (ADDR_W) in, onehot (NUM_OUT) out; an idx >= NUM_OUT gives all zeros.
// Latency: 0 cycles, no flow control.
module onehot_decoder
    import seq_decoder_pkg::*;
#(
    parameter int ADDR_W  = 2,
    parameter int NUM_OUT = 4
) (
    input  logic [ADDR_W-1:0]  idx,
    output logic [NUM_OUT-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            onehot[i] = (32'(idx) == i);
        end
    end

endmodule

// File: rtl/seq_decoder.sv
// Sequenced one-hot decoder with LEVEL / PULSE / SCAN modes and enable stall.
// Ports: clk, reset (async, active-high), enable, load, mode, address in;
//        ready, out, cur_addr, done out (+ err when SEQ_DECODER_RANGE_CHECK_EN is defined).
// Latency: out follows an accepted load by one cycle; load is taken only when ready & enable.
module seq_decoder
    import seq_decoder_pkg::*;
#(
    parameter int ADDR_W    = 2,
    parameter int NUM_OUT   = 4,
    parameter int PULSE_LEN = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               load,
    input  logic [1:0]         mode,
    input  logic [ADDR_W-1:0]  address,
    output logic               ready,
    output logic [NUM_OUT-1:0] out,
    output logic [ADDR_W-1:0]  cur_addr,
    output logic               done
`ifdef SEQ_DECODER_RANGE_CHECK_EN
    ,
    output logic               err
`endif
);

    localparam int CW = pulse_cnt_w(PULSE_LEN);

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [NUM_OUT-1:0]  dec, out_nxt;
    logic                done_nxt;
    logic                accept;
    logic                scan_last;

    assign ready  = (state == ST_IDLE) || (state == ST_HOLD);
    assign accept = load && ready && enable;

    // Cast up so the compare stays meaningful when NUM_OUT == 2**ADDR_W.
    assign scan_last = (32'(cur_addr) >= NUM_OUT - 1);

    // Decode the index that will be current after this edge, so out is
    // registered in step with cur_addr.
    onehot_decoder #(
        .ADDR_W  (ADDR_W),
        .NUM_OUT (NUM_OUT)
    ) u_dec (
        .idx    (addr_nxt),
        .onehot (dec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            cur_addr <= '0;
            out      <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            cur_addr <= addr_nxt;
            out      <= out_nxt;
            done     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = cur_addr;
        done_nxt  = 1'b0;

        // With enable low everything holds; only out and done drop to 0.
        if (enable) begin
            if (accept) begin
                addr_nxt = address;
                case (mode)
                    MODE_PULSE: begin
                        state_nxt = ST_PULSE;
                        cnt_nxt   = CW'(PULSE_LEN - 1);
                        done_nxt  = (PULSE_LEN == 1);
                    end
                    MODE_SCAN: begin
                        state_nxt = ST_SCAN;
                        done_nxt  = (32'(address) >= NUM_OUT - 1);
                    end
                    default: state_nxt = ST_HOLD;
                endcase
            end else begin
                case (state)
                    ST_PULSE: begin
                        // cnt == 0 marks the final visible cycle of the pulse.
                        if (cnt == '0) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            cnt_nxt  = cnt - 1'b1;
                            done_nxt = (cnt == CW'(1));
                        end
                    end
                    ST_SCAN: begin
                        if (scan_last) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            addr_nxt = cur_addr + 1'b1;
                            done_nxt = (32'(addr_nxt) == NUM_OUT - 1);
                        end
                    end
                    default: ;
                endcase
            end
        end

        out_nxt = (enable && (state_nxt != ST_IDLE)) ? dec : '0;
    end

`ifdef SEQ_DECODER_RANGE_CHECK_EN
    // Sticky flag for any accepted out-of-range index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (accept && (32'(address) >= NUM_OUT)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule
